// File: rtl/regfile.sv
// rtl/regfile.sv - N x WIDTH flip-flop register file, one write port, one registered write-first read port
module regfile #(
    parameter  int N          = 32,
    parameter  int WIDTH      = 32,
    localparam int ADDR_WIDTH = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] R_addr,
    input  logic                  R_en,
    output logic [WIDTH-1:0]      R_data,
    input  logic [ADDR_WIDTH-1:0] W_addr,
    input  logic                  W_en,
    input  logic [WIDTH-1:0]      W_data
);

    logic [WIDTH-1:0] mem_q [N];
    logic [WIDTH-1:0] mem_d [N];
    logic [WIDTH-1:0] r_data_q;
    logic [WIDTH-1:0] r_data_d;
    logic [N-1:0]     wr_sel;
    logic [WIDTH-1:0] rd_word;

    // One-hot write decode; addresses at or beyond N match no entry, so such writes vanish
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (W_en && (W_addr == ADDR_WIDTH'(i))) begin
                wr_sel[i] = 1'b1;
            end
        end
    end

    // Next-state of every entry: selected entry takes write data, the rest hold
    always_comb begin
        for (int i = 0; i < N; i++) begin
            mem_d[i] = wr_sel[i] ? W_data : mem_q[i];
        end
    end

    // Read mux with write-first bypass; out-of-range read addresses yield zero
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < N; i++) begin
            if (R_addr == ADDR_WIDTH'(i)) begin
                rd_word = mem_q[i];
            end
        end
        // Bypass only when the write actually lands, so a dropped write never leaks through
        if ((|wr_sel) && (W_addr == R_addr)) begin
            rd_word = W_data;
        end
        r_data_d = R_en ? rd_word : r_data_q;
    end

    // Storage and read register; asynchronous clear of everything on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '0;
            end
            r_data_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= mem_d[i];
            end
            r_data_q <= r_data_d;
        end
    end

    assign R_data = r_data_q;

endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - directed self-checking bench for regfile (N=32 and N=24 instances)
module tb_regfile;

    logic        clk;
    logic        rst_n;
    logic [4:0]  r_addr;
    logic        r_en;
    logic [4:0]  w_addr;
    logic        w_en;
    logic [31:0] w_data;
    logic [31:0] r_data_a;
    logic [31:0] r_data_b;

    int vectors;
    int errors;

    regfile #(.N(32), .WIDTH(32)) dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .R_addr (r_addr),
        .R_en   (r_en),
        .R_data (r_data_a),
        .W_addr (w_addr),
        .W_en   (w_en),
        .W_data (w_data)
    );

    regfile #(.N(24), .WIDTH(32)) dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .R_addr (r_addr),
        .R_en   (r_en),
        .R_data (r_data_b),
        .W_addr (w_addr),
        .W_en   (w_en),
        .W_data (w_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        w_en   = 1'b0;
        r_en   = 1'b0;
        w_addr = '0;
        r_addr = '0;
        w_data = '0;
    endtask

    initial begin
        logic [31:0] exp_v;
        vectors = 0;
        errors  = 0;
        rst_n   = 1'b0;
        idle();

        // Reset state
        step();
        step();
        check("reset_a", r_data_a, 32'h0);
        check("reset_b", r_data_b, 32'h0);
        rst_n = 1'b1;

        // Write then read addr 3, then asynchronous reset between edges
        w_en = 1'b1; w_addr = 5'd3; w_data = 32'hDEADBEEF;
        step();
        w_en = 1'b0; r_en = 1'b1; r_addr = 5'd3;
        step();
        check("pre_reset_rd", r_data_a, 32'hDEADBEEF);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_a", r_data_a, 32'h0);
        check("async_reset_b", r_data_b, 32'h0);
        step();
        rst_n = 1'b1;
        r_en = 1'b1; r_addr = 5'd3;
        step();
        check("post_reset_addr3", r_data_a, 32'h0);

        // Fill every address with i*0x01010101
        r_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            w_en = 1'b1; w_addr = 5'(i); w_data = 32'(i) * 32'h01010101;
            step();
        end
        w_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            r_en = 1'b1; r_addr = 5'(i);
            step();
            exp_v = 32'(i) * 32'h01010101;
            check($sformatf("fill_a[%0d]", i), r_data_a, exp_v);
            check($sformatf("fill_b[%0d]", i), r_data_b, (i < 24) ? exp_v : 32'h0);
        end

        // Read hold while R_en is low, even as the addressed entry is rewritten
        idle();
        w_en = 1'b1; w_addr = 5'd5; w_data = 32'h55;
        step();
        w_en = 1'b0; r_en = 1'b1; r_addr = 5'd5;
        step();
        check("hold_first_rd", r_data_a, 32'h55);
        r_en = 1'b0; w_en = 1'b1; w_addr = 5'd5; w_data = 32'hAA;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("hold_cyc%0d", k), r_data_a, 32'h55);
        end
        w_en = 1'b0; r_en = 1'b1; r_addr = 5'd5;
        step();
        check("hold_release", r_data_a, 32'hAA);

        // Write-first bypass on same address, same edge
        w_en = 1'b1; w_addr = 5'd7; w_data = 32'h1234;
        r_en = 1'b1; r_addr = 5'd7;
        step();
        check("bypass_a", r_data_a, 32'h1234);
        check("bypass_b", r_data_b, 32'h1234);

        // Disabled write leaves the entry untouched
        w_en = 1'b0; w_addr = 5'd2; w_data = 32'hFFFF; r_en = 1'b0;
        step();
        r_en = 1'b1; r_addr = 5'd2;
        step();
        check("wdis_a", r_data_a, 32'h02020202);
        check("wdis_b", r_data_b, 32'h02020202);

        // Top and bottom addresses on consecutive cycles
        r_en = 1'b0;
        w_en = 1'b1; w_addr = 5'd31; w_data = 32'hA5A5A5A5;
        step();
        w_addr = 5'd0; w_data = 32'h5A5A5A5A;
        step();
        w_addr = 5'd23; w_data = 32'hC3C3C3C3;
        step();
        w_addr = 5'd0; w_data = 32'h3C3C3C3C;
        step();
        w_en = 1'b0; r_en = 1'b1; r_addr = 5'd31;
        step();
        check("edge_rd31_a", r_data_a, 32'hA5A5A5A5);
        check("edge_rd31_b", r_data_b, 32'h0);
        r_addr = 5'd23;
        step();
        check("edge_rd23_a", r_data_a, 32'hC3C3C3C3);
        check("edge_rd23_b", r_data_b, 32'hC3C3C3C3);
        r_addr = 5'd0;
        step();
        check("edge_rd0_a", r_data_a, 32'h3C3C3C3C);
        check("edge_rd0_b", r_data_b, 32'h3C3C3C3C);

        // Out-of-range write dropped in the N=24 instance
        r_en = 1'b0; w_en = 1'b1; w_addr = 5'd30; w_data = 32'h77777777;
        step();
        w_en = 1'b0; r_en = 1'b1; r_addr = 5'd30;
        step();
        check("oor_rd30_a", r_data_a, 32'h77777777);
        check("oor_rd30_b", r_data_b, 32'h0);

        // Out-of-range write with same-edge read must not bypass
        w_en = 1'b1; w_addr = 5'd30; w_data = 32'h99999999;
        r_en = 1'b1; r_addr = 5'd30;
        step();
        check("oor_bypass_a", r_data_a, 32'h99999999);
        check("oor_bypass_b", r_data_b, 32'h0);

        idle();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
